sync_fifo_flags: RTL and testbench

Parametrised single-clock FIFO for the processing system's same-clock datapaths. It generalises the team's FIFO to:
- any depth, including non-power-of-two;
- selectable standard or first-word-fall-through (FWFT) read mode;
- programmable almost-full/almost-empty thresholds, a fill-level output and sticky overflow/underflow error flags.

It sits between a same-clock producer and consumer, where no pointer synchronisation is needed.

---
 rtl/fifo_pkg.sv | 22 ++
 rtl/sync_fifo_mem.sv | 24 ++
 rtl/sync_fifo_flags.sv | 111 +++++++++++
 tb/tb_sync_fifo_flags.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: sizing helper, read-mode constants and parameter legality.
package fifo_pkg;

  localparam int unsigned FIFO_STD  = 0;
  localparam int unsigned FIFO_FWFT = 1;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) r++;
    return r;
  endfunction

  // Legal geometry: at least two entries, thresholds inside the reachable level range.
  function automatic bit params_legal(input int unsigned depth,
                                      input int unsigned af_thresh,
                                      input int unsigned ae_thresh);
    return (depth >= 2) && (af_thresh >= 1) && (af_thresh <= depth) &&
           (ae_thresh <= depth - 1);
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// FIFO storage: register array, synchronous write, asynchronous read, no reset.
module sync_fifo_mem
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16
) (
  input  logic                          clk,
  input  logic                          we,
  input  logic [clog2(DEPTH)-1:0]       waddr,
  input  logic [DATA_WIDTH-1:0]         wdata,
  input  logic [clog2(DEPTH)-1:0]       raddr,
  output logic [DATA_WIDTH-1:0]         rdata
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with any depth, standard/FWFT read, level, threshold and sticky error flags.
module sync_fifo_flags
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned AF_THRESH  = DEPTH - 2,
  parameter int unsigned AE_THRESH  = 2,
  parameter int unsigned FWFT       = FIFO_STD
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         w_inc,
  input  logic [DATA_WIDTH-1:0]        w_data,
  input  logic                         r_inc,
  input  logic                         err_clr,
  output logic [DATA_WIDTH-1:0]        r_data,
  output logic                         w_full,
  output logic                         r_empty,
  output logic                         almost_full,
  output logic                         almost_empty,
  output logic [clog2(DEPTH+1)-1:0]    level,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int unsigned PW = clog2(DEPTH);
  localparam int unsigned LW = clog2(DEPTH + 1);

  if (!params_legal(DEPTH, AF_THRESH, AE_THRESH)) begin : g_param_check
    $fatal(1, "sync_fifo_flags: illegal DEPTH/AF_THRESH/AE_THRESH combination");
  end

  logic [PW-1:0]         wptr_q, wptr_d;
  logic [PW-1:0]         rptr_q, rptr_d;
  logic [LW-1:0]         level_q, level_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  wr_ok, rd_ok;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign w_full       = (level_q == LW'(DEPTH));
  assign r_empty      = (level_q == '0);
  assign almost_full  = (level_q >= LW'(AF_THRESH));
  assign almost_empty = (level_q <= LW'(AE_THRESH));

  // Requests in a reset cycle are ignored, including the memory write.
  assign wr_ok = rst & w_inc & ~w_full;
  assign rd_ok = rst & r_inc & ~r_empty;

  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    level_d     = level_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    rdata_d     = rdata_q;
    if (!rst) begin
      wptr_d      = '0;
      rptr_d      = '0;
      level_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
      rdata_d     = '0;
    end else begin
      if (wr_ok) wptr_d = ptr_inc(wptr_q);
      if (rd_ok) rptr_d = ptr_inc(rptr_q);
      case ({wr_ok, rd_ok})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
      // A coinciding set beats err_clr.
      overflow_d  = (w_inc & w_full)  | (overflow_q  & ~err_clr);
      underflow_d = (r_inc & r_empty) | (underflow_q & ~err_clr);
      if ((FWFT == FIFO_STD) && rd_ok) rdata_d = mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    wptr_q      <= wptr_d;
    rptr_q      <= rptr_d;
    level_q     <= level_d;
    overflow_q  <= overflow_d;
    underflow_q <= underflow_d;
    rdata_q     <= rdata_d;
  end

  sync_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_ok),
    .waddr (wptr_q),
    .wdata (w_data),
    .raddr (rptr_q),
    .rdata (mem_rdata)
  );

  assign r_data    = (FWFT == FIFO_FWFT) ? (r_empty ? '0 : mem_rdata) : rdata_q;
  assign level     = level_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Bench: standard and FWFT instances driven in lockstep, checked against a queue model.
module tb_sync_fifo_flags;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 5;
  localparam int unsigned AF    = 4;
  localparam int unsigned AE    = 1;

  logic          clk = 1'b0;
  logic          rst, w_inc, r_inc, err_clr;
  logic [DW-1:0] w_data;

  logic [DW-1:0] r_data_s, r_data_f;
  logic          w_full_s, r_empty_s, af_s, ae_s, ovf_s, udf_s;
  logic          w_full_f, r_empty_f, af_f, ae_f, ovf_f, udf_f;
  logic [2:0]    level_s, level_f;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] q[$];
  logic          m_ovf, m_udf;
  logic [DW-1:0] m_rdata;

  always #5 clk = ~clk;

  sync_fifo_flags #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE),
                    .FWFT(0)) dut_std (
    .clk(clk), .rst(rst), .w_inc(w_inc), .w_data(w_data), .r_inc(r_inc), .err_clr(err_clr),
    .r_data(r_data_s), .w_full(w_full_s), .r_empty(r_empty_s), .almost_full(af_s),
    .almost_empty(ae_s), .level(level_s), .overflow(ovf_s), .underflow(udf_s));

  sync_fifo_flags #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE),
                    .FWFT(1)) dut_fwft (
    .clk(clk), .rst(rst), .w_inc(w_inc), .w_data(w_data), .r_inc(r_inc), .err_clr(err_clr),
    .r_data(r_data_f), .w_full(w_full_f), .r_empty(r_empty_f), .almost_full(af_f),
    .almost_empty(ae_f), .level(level_f), .overflow(ovf_f), .underflow(udf_f));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int unsigned n;
    n = q.size();
    chk("level_std",  32'(level_s),   32'(n));
    chk("level_fwft", 32'(level_f),   32'(n));
    chk("full_std",   32'(w_full_s),  32'(n == DEPTH));
    chk("full_fwft",  32'(w_full_f),  32'(n == DEPTH));
    chk("empty_std",  32'(r_empty_s), 32'(n == 0));
    chk("empty_fwft", 32'(r_empty_f), 32'(n == 0));
    chk("afull_std",  32'(af_s),      32'(n >= AF));
    chk("afull_fwft", 32'(af_f),      32'(n >= AF));
    chk("aempty_std", 32'(ae_s),      32'(n <= AE));
    chk("aempty_fwft",32'(ae_f),      32'(n <= AE));
    chk("ovf_std",    32'(ovf_s),     32'(m_ovf));
    chk("ovf_fwft",   32'(ovf_f),     32'(m_ovf));
    chk("udf_std",    32'(udf_s),     32'(m_udf));
    chk("udf_fwft",   32'(udf_f),     32'(m_udf));
    chk("rdata_std",  32'(r_data_s),  32'(m_rdata));
    chk("rdata_fwft", 32'(r_data_f),  (n == 0) ? 32'd0 : 32'(q[0]));
  endtask

  // One clock: drive requests, advance the model by the FIFO's rules, check after the edge.
  task automatic step(input logic w, input logic [DW-1:0] d, input logic r,
                      input logic clr, input logic rn);
    logic full, empty;
    w_inc = w; w_data = d; r_inc = r; err_clr = clr; rst = rn;
    if (!rn) begin
      q.delete();
      m_ovf = 1'b0; m_udf = 1'b0; m_rdata = '0;
    end else begin
      full  = (q.size() == DEPTH);
      empty = (q.size() == 0);
      if (r && !empty) m_rdata = q.pop_front();
      if (w && !full) q.push_back(d);
      m_ovf = (w && full)  ? 1'b1 : (clr ? 1'b0 : m_ovf);
      m_udf = (r && empty) ? 1'b1 : (clr ? 1'b0 : m_udf);
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    rst = 1'b0; w_inc = 1'b0; r_inc = 1'b0; err_clr = 1'b0; w_data = '0;
    q.delete(); m_ovf = 1'b0; m_udf = 1'b0; m_rdata = '0;
    #1;

    // Reset and fill
    step(0, 8'h00, 0, 0, 0);
    step(0, 8'h00, 0, 0, 0);
    chk("reset_rdata", 32'(r_data_s), 32'h0);
    for (int i = 1; i <= 5; i++) step(1, 8'(8'h11 * i), 0, 0, 1);
    chk("fill_level", 32'(level_s), 32'd5);

    // Overflow while full, then clear
    step(1, 8'h66, 0, 0, 1);
    chk("ovf_set", 32'(ovf_s), 32'd1);
    step(0, 8'h00, 0, 1, 1);
    chk("ovf_clr", 32'(ovf_s), 32'd0);

    // Drain and underflow in standard mode
    for (int i = 0; i < 5; i++) step(0, 8'h00, 1, 0, 1);
    chk("drain_last", 32'(r_data_s), 32'h55);
    step(0, 8'h00, 1, 0, 1);
    chk("udf_set", 32'(udf_s), 32'd1);
    chk("udf_hold", 32'(r_data_s), 32'h55);
    step(0, 8'h00, 0, 1, 1);

    // Simultaneous read/write at full
    for (int i = 0; i < 5; i++) step(1, 8'(8'hA0 + i), 0, 0, 1);
    step(1, 8'h77, 1, 0, 1);
    chk("full_rw_level", 32'(level_s), 32'd4);
    chk("full_rw_pop", 32'(r_data_s), 32'hA0);
    step(0, 8'h00, 0, 1, 1);

    // Wrap-around in FWFT mode at a steady level of 2
    while (q.size() > 2) step(0, 8'h00, 1, 0, 1);
    for (int i = 0; i < 12; i++) step(1, 8'(8'hC0 + i), 1, 0, 1);
    chk("wrap_level", 32'(level_f), 32'd2);

    // Reset mid-stream with a write in the reset cycle
    step(1, 8'hE0, 0, 0, 1);
    chk("pre_rst_level", 32'(level_s), 32'd3);
    step(1, 8'hAA, 0, 0, 0);
    chk("mid_rst_level", 32'(level_f), 32'd0);
    chk("mid_rst_rdata", 32'(r_data_f), 32'd0);

    // Randomized traffic, including occasional error clears and resets
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 99) < 55), 8'($urandom), 1'($urandom_range(0, 99) < 50),
           1'($urandom_range(0, 99) < 5), 1'($urandom_range(0, 99) >= 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
